wtm_mul_arbiter: RTL and testbench
==================================

Name: wtm_mul_arbiter

Overview:
- Shares one registered 32x32 signed Wallace-tree multiplier among NUM_REQ requesters. Issues at most one operation per cycle.
- Tracks in-flight operations through a tag pipeline matched to the multiplier latency. Returns each 64-bit product to its originating requester.
- Sits between requester blocks and the multiplier instance. Also provides enable/drain control so software can quiesce the multiplier.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MUL_LATENCY, 2, clock edges from mul_a/mul_b update to valid mul_result (1..8)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_enable  in  1  1 = grant requests; 0 = stop granting and drain
- idle  out  1  1 when state OFF (nothing in flight, not granting)
- req_valid  in  NUM_REQ  per-requester operation valid
- req_a  in  32*NUM_REQ  signed operand A, requester i at [32*i+31:32*i]
- req_b  in  32*NUM_REQ  signed operand B, same packing
- req_ready  out  NUM_REQ  one-hot grant, combinational
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse, registered
- rsp_result  out  64  signed product for the rsp_valid requester, registered
- mul_a  out  32  to multiplier A, registered
- mul_b  out  32  to multiplier B, registered
- mul_result  in  64  from multiplier Result

Behaviour:
- Reset (reset=0, asynchronous):
  - req_ready=0, rsp_valid=0, rsp_result=0, mul_a=0, mul_b=0.
  - Tag pipeline cleared, priority pointer=0, state=OFF, idle=1.
- States: OFF, RUN, DRAIN.
  - OFF -> RUN when cfg_enable=1.
  - RUN -> DRAIN when cfg_enable=0.
  - DRAIN -> OFF when tag pipeline is empty.
  - DRAIN -> RUN if cfg_enable returns to 1 before the pipeline empties.
- Grants:
  - req_ready is nonzero only in RUN.
  - Exactly one bit is set, selected among req_valid bits by the arbitration policy (see Optional Feature).
  - req_ready never depends on rsp signals.
- Issue: a handshake on requester i at edge T does all of the following:
  - loads mul_a/mul_b with req_a[i]/req_b[i];
  - pushes tag {valid=1, idx=i} into the tag pipeline;
  - if round-robin is compiled in, sets pointer to i+1 mod NUM_REQ.
- Idle cycles: with no handshake, mul_a/mul_b hold their previous values and a tag with valid=0 is pushed.
- Tag pipeline: MUL_LATENCY stages, shifting every cycle.
  - When the tag leaving the last stage has valid=1, at that same edge (T+MUL_LATENCY): rsp_result <= mul_result and rsp_valid <= one-hot(idx).
  - Otherwise rsp_valid <= 0 and rsp_result holds its previous value.
- Latency: a handshake at edge T makes rsp_valid visible in the cycle after edge T+MUL_LATENCY (3 edges inclusive for default 2).
- Throughput: one issue per cycle. Responses return in issue order. Back-to-back issues produce back-to-back responses.
- Responses: no backpressure. Requesters must accept the rsp_valid pulse.
- Arithmetic: two's-complement, full 64-bit result, no truncation or saturation. 0x80000000*0x80000000 = 0x4000000000000000.
- Boundary conditions:
  - cfg_enable falls in the same cycle as a handshake: the handshake completes, then the state goes to DRAIN.
  - Reset mid-operation: all in-flight tags are discarded and no rsp_valid is emitted for them.
  - A requester holding req_valid without ready keeps its operands stable; no operand is ever dropped or duplicated.
- Tag idx width: clog2(NUM_REQ).

Optional Feature:
- Macro: WTM_MUL_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at pointer and wraps; pointer advances past the granted index only on a handshake.
- Undefined: fixed priority, lowest index wins, and the pointer register is not instantiated.

Test Plan:
- Single request, requester 0: a=125, b=38 -> rsp_valid=4'b0001 after MUL_LATENCY+1 edges, rsp_result=4750.
- Signed corners, back-to-back on requester 1, one per cycle:
  - (-125,38) -> -4750
  - (125,-38) -> -4750
  - (-125,-38) -> 4750
  - (0x80000000,0x7FFFFFFF) -> 0xC000000080000000
  - (0x80000000,0x80000000) -> 0x4000000000000000
  - Results arrive on consecutive cycles, in order.
- All 4 requesters hold req_valid continuously, requester i operands (i+1, 5):
  - RR build: grants cycle 0,1,2,3,0...; results 5,10,15,20 tagged to the matching requesters.
  - Fixed-priority build: only requester 0 is granted.
- Drain: issue 2 operations, drop cfg_enable the next cycle -> no further req_ready, both results delivered, idle=1 one cycle after the last rsp_valid.
- Reset asserted with 2 operations in flight -> all outputs 0 immediately. After release with cfg_enable=0: no rsp_valid, idle=1.
- Zero/identity: (0,5)->0, (1,5)->5, (1,-5)->-5, (-1,-5)->5, (0,0)->0.

Source files
------------

// File: rtl/wtm_mul_arbiter.sv
// Shares one pipelined 32x32 signed multiplier among NUM_REQ requesters.
// Define WTM_MUL_ARB_RR_EN for round-robin grants; fixed priority otherwise.
module wtm_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_enable,
  output logic                 idle,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [63:0]          rsp_result,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_result
);

  localparam int IW = $clog2(NUM_REQ);

  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    logic v;
    idx_t idx;
  } tag_t;

  typedef enum logic [1:0] {
    S_OFF,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  tag_t               tag_q [MUL_LATENCY];
  tag_t               tag_in, tag_out;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [63:0]        rsp_result_q, rsp_result_d;
  logic               gnt_any, fire, pipe_empty;
  idx_t               gnt_idx, cidx;

`ifdef WTM_MUL_ARB_RR_EN
  idx_t ptr_q, ptr_d;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cidx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cidx = idx_t'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any && req_valid[cidx]) begin
        gnt_any = 1'b1;
        gnt_idx = cidx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      ptr_d = (gnt_idx == idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cidx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cidx = idx_t'(k);
      if (!gnt_any && req_valid[cidx]) begin
        gnt_any = 1'b1;
        gnt_idx = cidx;
      end
    end
  end
`endif

  // Grant depends only on state and req_valid, never on cfg_enable,
  // so a handshake in the cycle cfg_enable falls still completes.
  assign fire      = (state_q == S_RUN) && gnt_any;
  assign req_ready = fire ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign tag_out   = tag_q[MUL_LATENCY-1];
  assign tag_in    = '{v: fire, idx: (fire ? gnt_idx : '0)};

  always_comb begin
    pipe_empty = 1'b1;
    for (int k = 0; k < MUL_LATENCY; k++) begin
      if (tag_q[k].v) pipe_empty = 1'b0;
    end
  end

  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (fire) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (idx_t'(k) == gnt_idx) begin
          mul_a_d = req_a[32*k +: 32];
          mul_b_d = req_b[32*k +: 32];
        end
      end
    end
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    if (tag_out.v) begin
      rsp_valid_d  = NUM_REQ'(1) << tag_out.idx;
      rsp_result_d = mul_result;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF:   if (cfg_enable) state_d = S_RUN;
      S_RUN:   if (!cfg_enable) state_d = S_DRAIN;
      S_DRAIN: begin
        if (cfg_enable)      state_d = S_RUN;
        else if (pipe_empty) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_OFF;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      tag_q[0]     <= tag_in;
      for (int k = 1; k < MUL_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign idle       = (state_q == S_OFF);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_wtm_mul_arbiter.sv
// Randomized and directed bench for wtm_mul_arbiter with a queue-based
// reference model and a pipelined multiplier stand-in.
module tb_wtm_mul_arbiter;

  localparam int N = 4;
  localparam int L = 2;
  localparam int M_OFF = 0, M_RUN = 1, M_DRAIN = 2;

  logic            clk, reset, cfg_enable, idle;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [63:0]     rsp_result, mul_result;
  logic [31:0]     mul_a, mul_b;

  wtm_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .idle(idle),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    if (L == 1) begin : g_comb
      assign mul_result = longint'($signed(mul_a)) * longint'($signed(mul_b));
    end else begin : g_pipe
      logic [63:0] mp [L-1];
      initial for (int k = 0; k < L-1; k++) mp[k] = '0;
      always @(posedge clk) begin
        mp[0] <= longint'($signed(mul_a)) * longint'($signed(mul_b));
        for (int k = 1; k < L-1; k++) mp[k] <= mp[k-1];
      end
      assign mul_result = mp[L-2];
    end
  endgenerate

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct { int due; int r; logic [63:0] p; } fl_t;
  typedef struct { int r; logic [31:0] a; logic [31:0] b; } op_t;

  fl_t         m_q [$];
  op_t         feed [$];
  int          m_state, m_ptr, m_cyc, m_gnt;
  logic [N-1:0] exp_rv;
  logic [63:0] exp_rr;
  logic [31:0] exp_ma, exp_mb;
  logic        rq_v [N];
  logic [31:0] rq_a [N], rq_b [N];
  bit          hold;

  function automatic logic [63:0] prod(input logic [31:0] a,
                                       input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic int pick(input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (rq_v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_state = M_OFF;
    m_ptr   = 0;
    exp_rv  = '0;
    exp_rr  = '0;
    exp_ma  = '0;
    exp_mb  = '0;
  endtask

  task automatic model_edge(input int g);
    bit empty;
    fl_t e;
    empty  = (m_q.size() == 0);
    exp_rv = '0;
    if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
      e = m_q.pop_front();
      exp_rv[e.r] = 1'b1;
      exp_rr = e.p;
    end
    if (g >= 0) begin
      exp_ma = rq_a[g];
      exp_mb = rq_b[g];
      m_q.push_back('{m_cyc + L, g, prod(rq_a[g], rq_b[g])});
      m_ptr = (g + 1) % N;
    end
    case (m_state)
      M_OFF:   if (cfg_enable) m_state = M_RUN;
      M_RUN:   if (!cfg_enable) m_state = M_DRAIN;
      default: if (cfg_enable) m_state = M_RUN;
               else if (empty) m_state = M_OFF;
    endcase
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = rq_v[i];
      req_a[32*i +: 32] = rq_a[i];
      req_b[32*i +: 32] = rq_b[i];
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    int g;
    logic [N-1:0] exp_ready;
    #1;
`ifdef WTM_MUL_ARB_RR_EN
    g = (m_state == M_RUN) ? pick(m_ptr) : -1;
`else
    g = (m_state == M_RUN) ? pick(0) : -1;
`endif
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    @(posedge clk);
    m_cyc++;
    model_edge(g);
    #1;
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_result", rsp_result, exp_rr);
    chk("mul_a", mul_a, exp_ma);
    chk("mul_b", mul_b, exp_mb);
    chk("idle", idle, m_state == M_OFF);
    m_gnt = g;
    @(negedge clk);
  endtask

  task automatic refill();
    for (int i = 0; i < N; i++) begin
      if (!rq_v[i] && feed.size() > 0 && feed[0].r == i) begin
        rq_v[i] = 1'b1;
        rq_a[i] = feed[0].a;
        rq_b[i] = feed[0].b;
        void'(feed.pop_front());
      end
    end
  endtask

  task automatic cyc();
    refill();
    drive();
    tick();
    if (m_gnt >= 0 && !hold) rq_v[m_gnt] = 1'b0;
  endtask

  task automatic add_op(input int r, input logic [31:0] a,
                        input logic [31:0] b);
    feed.push_back('{r, a, b});
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (rq_v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_feed(input int maxc);
    int n;
    n = 0;
    while ((feed.size() > 0 || any_pending() || m_q.size() > 0) && n < maxc) begin
      cyc();
      n++;
    end
    chk("feed_done", 64'(feed.size() + m_q.size()), 64'd0);
  endtask

  task automatic clear_rq();
    for (int i = 0; i < N; i++) begin
      rq_v[i] = 1'b0;
      rq_a[i] = '0;
      rq_b[i] = '0;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      2:       return 32'hffff_ffff;
      3:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    cfg_enable = 1'b0;
    hold = 1'b0;
    m_cyc = 0;
    m_gnt = -1;
    clear_rq();
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_result", rsp_result, '0);
    chk("rst_mul_a", mul_a, '0);
    chk("rst_mul_b", mul_b, '0);
    chk("rst_idle", idle, 1'b1);
    reset = 1'b1;

    cfg_enable = 1'b1;
    add_op(0, 125, 38);
    run_feed(20);
    chk("single_4750", rsp_result, 64'd4750);

    add_op(1, -125, 38);
    add_op(1, 125, -38);
    add_op(1, -125, -38);
    add_op(1, 32'h8000_0000, 32'h7fff_ffff);
    add_op(1, 32'h8000_0000, 32'h8000_0000);
    run_feed(30);
    chk("corner_min_sq", rsp_result, 64'h4000_0000_0000_0000);

    hold = 1'b1;
    for (int i = 0; i < N; i++) begin
      rq_v[i] = 1'b1;
      rq_a[i] = 32'(i + 1);
      rq_b[i] = 5;
    end
    repeat (10) cyc();
    hold = 1'b0;
    clear_rq();
    repeat (L + 2) cyc();

    add_op(3, 0, 5);
    add_op(3, 1, 5);
    add_op(3, 1, -5);
    add_op(3, -1, -5);
    add_op(3, 0, 0);
    run_feed(30);

    add_op(2, 7, 9);
    cyc();
    add_op(2, -3, 11);
    cfg_enable = 1'b0;
    cyc();
    rq_v[3] = 1'b1;
    rq_a[3] = 1;
    rq_b[3] = 1;
    repeat (L + 4) cyc();
    chk("drain_idle", idle, 1'b1);
    rq_v[3] = 1'b0;

    cfg_enable = 1'b1;
    cyc();
    add_op(0, 11, 13);
    add_op(1, -17, 19);
    cyc();
    cyc();
    chk("pre_reset_inflight", 64'(m_q.size()), 64'd2);
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_ready", req_ready, '0);
    chk("arst_rsp_valid", rsp_valid, '0);
    chk("arst_rsp_result", rsp_result, '0);
    chk("arst_mul_a", mul_a, '0);
    chk("arst_mul_b", mul_b, '0);
    chk("arst_idle", idle, 1'b1);
    clear_rq();
    feed.delete();
    drive();
    @(negedge clk);
    cfg_enable = 1'b0;
    reset = 1'b1;
    repeat (6) cyc();
    chk("post_reset_idle", idle, 1'b1);

    cfg_enable = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 31) == 0) cfg_enable = ~cfg_enable;
      for (int i = 0; i < N; i++) begin
        if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
          rq_v[i] = 1'b1;
          rq_a[i] = rnd_op();
          rq_b[i] = rnd_op();
        end
      end
      drive();
      tick();
      if (m_gnt >= 0) rq_v[m_gnt] = 1'b0;
    end
    clear_rq();
    cfg_enable = 1'b1;
    repeat (L + 3) cyc();
    chk("rand_drained", 64'(m_q.size()), 64'd0);
    cfg_enable = 1'b0;
    repeat (3) cyc();
    chk("final_idle", idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
